alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
Parametrised successor to the pipeline's single-cycle ALU. It adds registered outputs, a valid/ready handshake, an iterative multiply/divide unit with HI/LO registers, and a flush input. It sits in the EX stage. The pipeline stalls while in_ready is low and captures the result when out_valid and out_ready are both high.

Parameters:
WIDTH, 32, datapath width in bits; even, at least 8.
OP_W, 5, opcode width.
SH_W, $clog2(WIDTH), shift-amount bits taken from opnd1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept an operation this cycle
in_op  in  OP_W  opcode (encodings in package)
in_opnd1  in  WIDTH  rs or shift amount (sa)
in_opnd2  in  WIDTH  rt or extended immediate
flush  in  1  abort current operation (branch/exception)
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_res  out  WIDTH  result
out_err  out  1  opcode was undefined
busy  out  1  multiply/divide in progress
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n is low at a clk edge: state=IDLE; out_valid, out_err and busy are 0; out_res, hi and lo are 0. in_ready is low during reset.
- Accept rule: an operation is accepted when in_valid and in_ready are both high. in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Single-cycle ops (ADD SUB AND OR XOR NOR SLT SLTU SLL SRL SRA LUI MFHI MFLO MTHI MTLO):
  - Result is registered into out_res with out_valid=1 on the edge after acceptance (latency 1).
  - Back-to-back throughput is one op per cycle.
- Arithmetic and width rules:
  - ADD and SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT is a signed compare, SLTU unsigned; result is 0 or 1.
  - Shifts move opnd2 by opnd1[SH_W-1:0]. SRA replicates the sign bit.
  - LUI = opnd2 << WIDTH/2.
- HI/LO ops:
  - MTHI writes hi=opnd1 and MTLO writes lo=opnd1, both on the accept edge; out_res=opnd1.
  - MFHI and MFLO return the current hi or lo.
- Undefined opcode: out_res=0 and out_err=1 with a normal 1-cycle response. out_err is 0 for every defined op.
- MULT/MULTU/DIV/DIVU: accept moves IDLE to MUL or DIV with busy=1.
  - Operands are latched and a cycle counter is loaded with WIDTH.
  - One radix-2 iteration runs per cycle: shift-add for multiply, restoring for divide. Signed variants work on magnitudes and apply a sign fixup at the end.
  - When the counter reaches 0: hi/lo are written, busy=0, out_valid=1, out_res=lo, and state returns to IDLE. Total latency is WIDTH+1 cycles from accept to out_valid.
- Multiply result: {hi,lo} is the 2*WIDTH-bit product.
- Divide result: lo=quotient, hi=remainder. The quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: lo = all ones, hi = dividend. No error flag.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): lo = -2^(WIDTH-1), hi = 0.
- Output hold: out_res and out_err are held stable while out_valid && !out_ready.
- Flush (highest priority after reset):
  - Next edge: state=IDLE, busy=0, out_valid=0. An in-flight mul/div is aborted and hi/lo are left unmodified.
  - An op presented in the same cycle as flush is not accepted.
- Reset mid-operation behaves like flush, and additionally clears hi/lo.
- in_valid while busy is ignored (in_ready=0). Input contents are don't-care when in_valid=0.

Decomposition:
- Package alu_pkg holds:
  - the OP_W opcode localparams: ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOR=5 SLT=6 SLTU=7 SLL=8 SRL=9 SRA=10 LUI=11 MULT=16 MULTU=17 DIV=18 DIVU=19 MFHI=20 MFLO=21 MTHI=22 MTLO=23;
  - the state encoding IDLE/MUL/DIV.
- One sub-module, mdu_iter. It owns the iterative multiply/divide datapath and counter, with a start/done interface and operand/result ports. alu_mdu contains the single-cycle logic, the handshake, the HI/LO registers and the FSM.

Test Plan:
- Reset: hold rst_n=0 for 3 edges mid-stream -> out_valid=0, busy=0, hi=lo=0; in_ready=1 on the first cycle after release.
- Single-cycle ops, back-to-back with out_ready=1:
  - ADD 0xFFFFFFFF+1 -> 0x00000000
  - SLT 0x80000000,1 -> 1
  - SLTU 0x80000000,1 -> 0
  - SRA sa=4 on 0xF0000000 -> 0xFF000000
  - LUI 0x1234 -> 0x12340000
  - one result per cycle.
- MULT and divide:
  - MULT 0xFFFFFFFE × 3 -> out_valid exactly 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA; in_ready=0 throughout.
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide edge cases:
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Flush and busy:
  - Flush 10 cycles into a MULTU -> out_valid never rises, hi/lo keep their prior values, busy=0 on the next cycle.
  - MFLO issued during busy is stalled, then returns the new lo.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result -> out_res stable and in_ready=0; release -> next op accepted the same cycle. Undefined op 31 -> out_res=0, out_err=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by alu_mdu and its testbench.
// Opcodes are plain integers so they compare cleanly against any OP_W-wide opcode field.
package alu_pkg;

    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_AND   = 2;
    localparam int unsigned OP_OR    = 3;
    localparam int unsigned OP_XOR   = 4;
    localparam int unsigned OP_NOR   = 5;
    localparam int unsigned OP_SLT   = 6;
    localparam int unsigned OP_SLTU  = 7;
    localparam int unsigned OP_SLL   = 8;
    localparam int unsigned OP_SRL   = 9;
    localparam int unsigned OP_SRA   = 10;
    localparam int unsigned OP_LUI   = 11;
    localparam int unsigned OP_MULT  = 16;
    localparam int unsigned OP_MULTU = 17;
    localparam int unsigned OP_DIV   = 18;
    localparam int unsigned OP_DIVU  = 19;
    localparam int unsigned OP_MFHI  = 20;
    localparam int unsigned OP_MFLO  = 21;
    localparam int unsigned OP_MTHI  = 22;
    localparam int unsigned OP_MTLO  = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply (shift-add) / divide (restoring) datapath.
// Signed operations run on magnitudes; the sign fixup is applied combinationally on the
// result ports. done is high for the single cycle in which the counter has reached 0.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             abort any operation in progress
//   start             load operands and begin (ignored while flush/reset)
//   is_div, is_signed operation select
//   opnd_a, opnd_b    multiplicand/multiplier or dividend/divisor
//   done              result valid this cycle
//   res_hi, res_lo    product {hi,lo} or remainder/quotient
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic [WIDTH-1:0] opnd_b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Multiply: acc = {partial product, multiplier}. Divide: acc = {remainder, quotient}.
    logic [2*WIDTH:0]   acc_q, acc_step;
    logic [WIDTH-1:0]   opb_q, dvd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               run_q, div_q, neg_q, rneg_q, dz_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign a_neg = is_signed & opnd_a[WIDTH-1];
    assign b_neg = is_signed & opnd_b[WIDTH-1];
    assign mag_a = a_neg ? (0 - opnd_a) : opnd_a;
    assign mag_b = b_neg ? (0 - opnd_b) : opnd_b;

    always_comb begin
        mul_sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_diff  = div_shift - {1'b0, opb_q};
        // Invariant rem < divisor keeps both candidates within WIDTH bits.
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        if (div_q) begin
            acc_step = {1'b0, div_rem, acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:0]} >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            run_q  <= 1'b1;
            cnt_q  <= CNT_W'(WIDTH);
            acc_q  <= {{(WIDTH+1){1'b0}}, mag_a};
            opb_q  <= mag_b;
            dvd_q  <= opnd_a;
            div_q  <= is_div;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            dz_q   <= (opnd_b == '0);
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                acc_q <= acc_step;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign done   = run_q && (cnt_q == '0);
    assign prod   = acc_q[2*WIDTH-1:0];
    assign prod_s = neg_q ? (0 - prod) : prod;

    always_comb begin
        if (!div_q) begin
            res_hi = prod_s[2*WIDTH-1:WIDTH];
            res_lo = prod_s[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi = dvd_q;
            res_lo = '1;
        end else begin
            // Quotient truncates toward zero; remainder follows the dividend's sign.
            res_lo = neg_q  ? (0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            res_hi = rneg_q ? (0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with registered result, valid/ready handshake, HI/LO registers and
// an iterative multiply/divide unit (mdu_iter). Single-cycle ops respond one edge after
// accept; mul/div respond WIDTH+1 edges after accept.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operation handshake; in_op, in_opnd1, in_opnd2 operation fields
//   flush                abort in-flight mul/div, drop pending result, block accept
//   out_valid/out_ready  result handshake; out_res result, out_err undefined opcode
//   busy                 multiply/divide in progress
//   hi, lo               HI/LO registers
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 5,
    parameter int unsigned SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_opnd1,
    input  logic [WIDTH-1:0] in_opnd2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_err,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state_q;
    logic             accept, md_done;
    logic             is_md, md_div, md_signed, alu_err;
    logic [WIDTH-1:0] alu_res, md_hi, md_lo;
    logic [SH_W-1:0]  sa;
    int unsigned      op_u;

    assign in_ready = rst_n && (state_q == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign op_u     = 32'(in_op);
    assign sa       = in_opnd1[SH_W-1:0];

    always_comb begin
        alu_res   = '0;
        alu_err   = 1'b0;
        is_md     = 1'b0;
        md_div    = 1'b0;
        md_signed = 1'b0;
        case (op_u)
            OP_ADD:   alu_res = in_opnd1 + in_opnd2;
            OP_SUB:   alu_res = in_opnd1 - in_opnd2;
            OP_AND:   alu_res = in_opnd1 & in_opnd2;
            OP_OR:    alu_res = in_opnd1 | in_opnd2;
            OP_XOR:   alu_res = in_opnd1 ^ in_opnd2;
            OP_NOR:   alu_res = ~(in_opnd1 | in_opnd2);
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(in_opnd1) < $signed(in_opnd2)};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, in_opnd1 < in_opnd2};
            OP_SLL:   alu_res = in_opnd2 << sa;
            OP_SRL:   alu_res = in_opnd2 >> sa;
            OP_SRA:   alu_res = $unsigned($signed(in_opnd2) >>> sa);
            OP_LUI:   alu_res = in_opnd2 << (WIDTH / 2);
            OP_MFHI:  alu_res = hi;
            OP_MFLO:  alu_res = lo;
            OP_MTHI,
            OP_MTLO:  alu_res = in_opnd1;
            OP_MULT:  begin is_md = 1'b1; md_signed = 1'b1; end
            OP_MULTU: is_md = 1'b1;
            OP_DIV:   begin is_md = 1'b1; md_div = 1'b1; md_signed = 1'b1; end
            OP_DIVU:  begin is_md = 1'b1; md_div = 1'b1; end
            default:  alu_err = 1'b1;
        endcase
    end

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .start     (accept && is_md),
        .is_div    (md_div),
        .is_signed (md_signed),
        .opnd_a    (in_opnd1),
        .opnd_b    (in_opnd2),
        .done      (md_done),
        .res_hi    (md_hi),
        .res_lo    (md_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_res   <= '0;
            busy      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (flush) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_md) begin
                            state_q <= md_div ? DIV : MUL;
                            busy    <= 1'b1;
                        end else begin
                            out_valid <= 1'b1;
                            out_res   <= alu_res;
                            out_err   <= alu_err;
                            if (op_u == OP_MTHI) hi <= in_opnd1;
                            if (op_u == OP_MTLO) lo <= in_opnd1;
                        end
                    end
                end
                MUL, DIV: begin
                    if (md_done) begin
                        state_q   <= IDLE;
                        busy      <= 1'b0;
                        hi        <= md_hi;
                        lo        <= md_lo;
                        out_res   <= md_lo;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, out_err, busy;
    logic [4:0]  in_op;
    logic [31:0] in_opnd1, in_opnd2, out_res, hi, lo;

    alu_mdu #(.WIDTH(32), .OP_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_opnd1(in_opnd1), .in_opnd2(in_opnd2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_err(out_err), .busy(busy),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic err; } vec_t;
    typedef struct { logic [31:0] res; logic err; } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Scoreboard: every transferred result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h want none", out_res);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_res", out_res, e.res);
                check("sb_err", {31'b0, out_err}, {31'b0, e.err});
            end
        end
    end

    // Present an op and hold it until accepted; expectation is queued at the accept edge.
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic err, input bit push,
                         output int waits);
        exp_t e;
        in_valid = 1'b1;
        in_op    = 5'(op);
        in_opnd1 = a;
        in_opnd2 = b;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got waits=%0d want accept", waits);
                break;
            end
        end
        if (in_ready) begin
            acc_cyc = cyc;
            if (push) begin
                e.res = res;
                e.err = err;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no out_valid want out_valid", name);
        end
    endtask

    vec_t vecs[14];

    initial begin
        int w, first_acc, nwait, n, a1, stall_bad, rose;

        vecs[0]  = '{5'(OP_ADD),  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[1]  = '{5'(OP_SUB),  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{5'(OP_AND),  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[3]  = '{5'(OP_OR),   32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0};
        vecs[4]  = '{5'(OP_XOR),  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
        vecs[5]  = '{5'(OP_NOR),  32'h00000000, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0};
        vecs[6]  = '{5'(OP_SLT),  32'h80000000, 32'h00000001, 32'h00000001, 1'b0};
        vecs[7]  = '{5'(OP_SLTU), 32'h80000000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[8]  = '{5'(OP_SLL),  32'h00000024, 32'h0000000F, 32'h000000F0, 1'b0};
        vecs[9]  = '{5'(OP_SRL),  32'h00000004, 32'hF0000000, 32'h0F000000, 1'b0};
        vecs[10] = '{5'(OP_SRA),  32'h00000004, 32'hF0000000, 32'hFF000000, 1'b0};
        vecs[11] = '{5'(OP_LUI),  32'h00000000, 32'h00001234, 32'h12340000, 1'b0};
        vecs[12] = '{5'd31,       32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
        vecs[13] = '{5'd12,       32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_opnd1 = '0; in_opnd2 = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single-cycle table, back to back.
        first_acc = 0; nwait = 0;
        for (int i = 0; i < 14; i++) begin
            issue(int'(vecs[i].op), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err, 1'b1, w);
            if (i == 0) first_acc = acc_cyc;
            nwait += w;
        end
        check("b2b_waits", 32'(nwait), 32'd0);
        check("b2b_span", 32'(acc_cyc - first_acc), 32'd13);
        @(posedge clk);
        #1;

        // MULT latency, in_ready low throughout.
        issue(OP_MULT, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b0, 1'b1, w);
        n = 0; stall_bad = 0;
        while (!out_valid && n < 200) begin
            if (in_ready || !busy) stall_bad++;
            @(posedge clk);
            #1;
            n++;
        end
        check("mult_latency", 32'(n), 32'd33);
        check("mult_stall", 32'(stall_bad), 32'd0);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, w);
        wait_valid("multu");
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);

        issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b1, w);
        wait_valid("div_neg");
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);

        issue(OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b1, w);
        wait_valid("div_negb");
        check("div_negb_lo", lo, 32'hFFFFFFFD);
        check("div_negb_hi", hi, 32'h00000001);

        issue(OP_DIVU, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, w);
        wait_valid("divu_z");
        check("divu_z_lo", lo, 32'hFFFFFFFF);
        check("divu_z_hi", hi, 32'h00000005);

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, w);
        wait_valid("div_ovf");
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h00000000);
        @(posedge clk);
        #1;

        // Flush a MULTU ten cycles in.
        issue(OP_MTHI, 32'hAAAA0000, 32'h0, 32'hAAAA0000, 1'b0, 1'b1, w);
        issue(OP_MTLO, 32'h00005555, 32'h0, 32'h00005555, 1'b0, 1'b1, w);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, w);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        // Op presented together with flush must be dropped.
        in_valid = 1'b1; in_op = 5'(OP_ADD); in_opnd1 = 32'd1; in_opnd2 = 32'd1; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        rose = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) rose++;
            @(posedge clk);
            #1;
        end
        check("flush_no_valid", 32'(rose), 32'd0);
        check("flush_hi", hi, 32'hAAAA0000);
        check("flush_lo", lo, 32'h00005555);

        // MFLO stalls behind a MULT and sees the new lo.
        issue(OP_MULT, 32'd3, 32'd5, 32'd15, 1'b0, 1'b1, w);
        a1 = acc_cyc;
        issue(OP_MFLO, 32'h0, 32'h0, 32'd15, 1'b0, 1'b1, w);
        check("mflo_stall", 32'(acc_cyc - a1), 32'd34);
        check("mflo_hi", hi, 32'd0);
        @(posedge clk);
        #1;

        // Backpressure.
        issue(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1, w);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 5'(OP_SUB); in_opnd1 = 32'd9; in_opnd2 = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_res", out_res, 32'd5);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(OP_SUB, 32'd9, 32'd4, 32'd5, 1'b0, 1'b1, w);
        check("bp_release_wait", 32'(w), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a MULT.
        issue(OP_MTHI, 32'h11, 32'h0, 32'h11, 1'b0, 1'b1, w);
        issue(OP_MTLO, 32'h22, 32'h0, 32'h22, 1'b0, 1'b1, w);
        issue(OP_MULT, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0, w);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mrst_in_ready", {31'b0, in_ready}, 32'd0);
        end
        check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_hi", hi, 32'd0);
        check("mrst_lo", lo, 32'd0);
        check("mrst_res", out_res, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_rel_ready", {31'b0, in_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("mrst_no_valid", {31'b0, out_valid}, 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
